// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a three-state IDLE/FETCH/ISSUE sequencer that reads one
// instruction word at a time, holds it for downstream, and advances the PC when it is consumed.
module instruction_fetch #(
  parameter int unsigned              WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0]     RESET_PC  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 hold,
  input  logic                 jump,
  input  logic [11:0]          jump_target,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] num_inst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state;

  assign address = pc;

  // readM and inst_valid are registered alongside the state so that each
  // transition sets the outputs of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      num_inst   <= '0;
      readM      <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= FETCH;
          readM      <= 1'b1;
          inst_valid <= 1'b0;
        end
        FETCH: begin
          if (inputReady) begin
            inst       <= data;
            state      <= ISSUE;
            readM      <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (!hold) begin
            if (jump)
              pc <= {pc[WORD_SIZE-1:12], jump_target};
            else
              pc <= pc + 1'b1;
            num_inst   <= num_inst + 1'b1;
            state      <= FETCH;
            readM      <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          readM      <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, zero-wait and wait-state fetch,
// hold stalls, jump paths, PC wrap and asynchronous reset during a fetch.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        readM;
  logic [15:0] address;
  logic [15:0] data = '0;
  logic        inputReady = 1'b0;
  logic        hold = 1'b0;
  logic        jump = 1'b0;
  logic [11:0] jump_target = '0;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] pc;
  logic [15:0] num_inst;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .readM(readM), .address(address), .data(data),
    .inputReady(inputReady), .hold(hold), .jump(jump), .jump_target(jump_target),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH: one zero-wait read, then a consume with the given jump.
  task automatic do_inst(input logic j, input logic [11:0] t);
    inputReady = 1'b1;
    step();
    inputReady  = 1'b0;
    hold        = 1'b0;
    jump        = j;
    jump_target = t;
    step();
    jump = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_readM", {15'd0, readM}, 16'h0000);
    chk("rst_valid", {15'd0, inst_valid}, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_num", num_inst, 16'h0000);
    step();
    step();
    reset = 1'b0;

    // Cycle 1: FETCH at RESET_PC
    step();
    chk("c1_readM", {15'd0, readM}, 16'h0001);
    chk("c1_valid", {15'd0, inst_valid}, 16'h0000);
    chk("c1_addr", address, 16'h0000);

    // Zero-wait memory
    inputReady = 1'b1;
    data = 16'h1234;
    step();
    chk("c2_valid", {15'd0, inst_valid}, 16'h0001);
    chk("c2_inst", inst, 16'h1234);
    chk("c2_readM", {15'd0, readM}, 16'h0000);
    inputReady = 1'b0;
    step();
    chk("c3_pc", pc, 16'h0001);
    chk("c3_num", num_inst, 16'h0001);
    chk("c3_readM", {15'd0, readM}, 16'h0001);
    chk("c3_valid", {15'd0, inst_valid}, 16'h0000);

    // Three wait states
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_readM", {15'd0, readM}, 16'h0001);
      chk("wait_addr", address, 16'h0001);
      chk("wait_valid", {15'd0, inst_valid}, 16'h0000);
    end
    inputReady = 1'b1;
    data = 16'h5678;
    step();
    chk("wait_done_valid", {15'd0, inst_valid}, 16'h0001);
    chk("wait_done_inst", inst, 16'h5678);

    // Hold for 5 cycles with noise on inputReady/data/jump
    hold = 1'b1;
    data = 16'hDEAD;
    jump = 1'b1;
    jump_target = 12'hF00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {15'd0, inst_valid}, 16'h0001);
      chk("hold_inst", inst, 16'h5678);
      chk("hold_pc", pc, 16'h0001);
      chk("hold_num", num_inst, 16'h0001);
      chk("hold_readM", {15'd0, readM}, 16'h0000);
    end
    hold = 1'b0;
    jump = 1'b0;
    inputReady = 1'b0;
    step();
    chk("unhold_pc", pc, 16'h0002);
    chk("unhold_num", num_inst, 16'h0002);
    chk("unhold_readM", {15'd0, readM}, 16'h0001);

    // Walk PC to 16'h2005 via jumps and carries
    do_inst(1'b1, 12'hFFF);
    chk("walk_0fff", pc, 16'h0FFF);
    do_inst(1'b0, 12'h000);
    chk("walk_1000", pc, 16'h1000);
    do_inst(1'b1, 12'hFFF);
    do_inst(1'b0, 12'h000);
    chk("walk_2000", pc, 16'h2000);
    do_inst(1'b1, 12'h005);
    chk("walk_2005", pc, 16'h2005);
    do_inst(1'b1, 12'hABC);
    chk("jump_pc", pc, 16'h2ABC);
    chk("jump_addr", address, 16'h2ABC);
    chk("jump_num", num_inst, 16'd8);
    chk("jump_readM", {15'd0, readM}, 16'h0001);

    // Walk up to 16'hFFFF, then wrap
    for (int i = 0; i < 13; i++) begin
      do_inst(1'b1, 12'hFFF);
      do_inst(1'b0, 12'h000);
    end
    chk("walk_f000", pc, 16'hF000);
    do_inst(1'b1, 12'hFFF);
    chk("walk_ffff", pc, 16'hFFFF);
    do_inst(1'b0, 12'h000);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_num", num_inst, 16'd36);

    // Asynchronous reset between edges while in FETCH
    chk("pre_rst_readM", {15'd0, readM}, 16'h0001);
    #2 reset = 1'b1;
    inputReady = 1'b1;
    data = 16'hBEEF;
    #1;
    chk("async_readM", {15'd0, readM}, 16'h0000);
    chk("async_valid", {15'd0, inst_valid}, 16'h0000);
    chk("async_pc", pc, 16'h0000);
    chk("async_num", num_inst, 16'h0000);
    chk("async_inst", inst, 16'h0000);
    step();
    chk("held_rst_readM", {15'd0, readM}, 16'h0000);
    #2 reset = 1'b0;
    step();
    chk("restart_readM", {15'd0, readM}, 16'h0001);
    chk("restart_addr", address, 16'h0000);
    chk("restart_inst", inst, 16'h0000);
    chk("restart_valid", {15'd0, inst_valid}, 16'h0000);
    chk("restart_num", num_inst, 16'h0000);
    step();
    chk("restart_fetch_inst", inst, 16'hBEEF);
    chk("restart_fetch_valid", {15'd0, inst_valid}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
